// File: rtl/ibex_vector_win_pkg.sv
// Shared constants for the 3x3 vector window generator.
// Byte slots of the packed window and the frame FSM states.
package ibex_vector_win_pkg;

  localparam int WIN_C  = 0;
  localparam int WIN_N  = 1;
  localparam int WIN_W  = 2;
  localparam int WIN_E  = 3;
  localparam int WIN_S  = 4;
  localparam int WIN_NW = 5;
  localparam int WIN_NE = 6;
  localparam int WIN_SW = 7;
  localparam int WIN_SE = 8;

  localparam int WIN_BYTES = 9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } win_state_e;

endpackage

// File: rtl/ibex_vector_line_buf.sv
// One line of pixel history.
// The read port is combinational; the write port uses the same address.
module ibex_vector_line_buf #(
  parameter int MAX_WIDTH = 64,
  parameter int AW        = $clog2(MAX_WIDTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [MAX_WIDTH];

  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/ibex_vector_window_gen.sv
// Streaming 3x3 window generator over a raster pixel stream.
// Define IBEX_VWIN_STALL_CNT_EN to enable the stall_cnt_o counter.
module ibex_vector_window_gen
  import ibex_vector_win_pkg::*;
#(
  parameter int MAX_WIDTH = 64,
  parameter int DIM_W     = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DIM_W-1:0] cfg_width_i,
  input  logic [DIM_W-1:0] cfg_height_i,
  output logic             cfg_err_o,
  output logic             busy_o,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  input  logic [7:0]       pix_data_i,
  output logic             win_valid_o,
  input  logic             win_ready_i,
  output logic [127:0]     win_data_o,
  output logic             frame_done_o,
  output logic [15:0]      stall_cnt_o
);

  localparam int AW = $clog2(MAX_WIDTH);
  localparam logic [DIM_W-1:0] MAX_W = DIM_W'(MAX_WIDTH);
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);
  localparam logic [DIM_W-1:0] TWO   = DIM_W'(2);
  localparam logic [DIM_W-1:0] THREE = DIM_W'(3);

  win_state_e       state_q;
  logic [DIM_W-1:0] w_q;
  logic [DIM_W-1:0] h_q;
  logic [DIM_W-1:0] row_q;
  logic [DIM_W-1:0] col_q;
  logic             win_valid_q;
  logic             frame_done_q;
  logic             cfg_err_q;

  // Index 2 is the newest column, index 0 the oldest.
  logic [2:0][7:0] w_t;
  logic [2:0][7:0] w_m;
  logic [2:0][7:0] w_b;

  logic [7:0] lb0_rd;
  logic [7:0] lb1_rd;
  logic       cfg_ok;
  logic       start_ok;
  logic       accept;
  logic       win_hs;
  logic       last_col;
  logic       last_pix;

  assign cfg_ok = cfg_width_i >= THREE &&
                  cfg_width_i <= MAX_W &&
                  cfg_height_i >= THREE;

  assign start_ok    = state_q == IDLE && start_i && cfg_ok;
  assign pix_ready_o = state_q == RUN &&
                       (!win_valid_q || win_ready_i);
  assign accept      = pix_valid_i && pix_ready_o;
  assign win_hs      = win_valid_q && win_ready_i;
  assign last_col    = col_q == w_q - ONE;
  assign last_pix    = last_col && row_q == h_q - ONE;

  assign busy_o       = state_q != IDLE;
  assign win_valid_o  = win_valid_q;
  assign frame_done_o = frame_done_q;
  assign cfg_err_o    = cfg_err_q;

  ibex_vector_line_buf #(
    .MAX_WIDTH (MAX_WIDTH),
    .AW        (AW)
  ) u_lb0 (
    .clk_i   (clk_i),
    .we_i    (accept),
    .addr_i  (col_q[AW-1:0]),
    .wdata_i (pix_data_i),
    .rdata_o (lb0_rd)
  );

  ibex_vector_line_buf #(
    .MAX_WIDTH (MAX_WIDTH),
    .AW        (AW)
  ) u_lb1 (
    .clk_i   (clk_i),
    .we_i    (accept),
    .addr_i  (col_q[AW-1:0]),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      w_q          <= '0;
      h_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      w_t          <= '0;
      w_m          <= '0;
      w_b          <= '0;
    end else begin
      cfg_err_q    <= state_q == IDLE && start_i && !cfg_ok;
      frame_done_q <= 1'b0;
      if (accept) begin
        win_valid_q <= row_q >= TWO && col_q >= TWO;
        w_t         <= {lb1_rd, w_t[2], w_t[1]};
        w_m         <= {lb0_rd, w_m[2], w_m[1]};
        w_b         <= {pix_data_i, w_b[2], w_b[1]};
      end else if (win_hs) begin
        win_valid_q <= 1'b0;
      end
      unique case (1'b1)
        (state_q == IDLE): begin
          if (start_ok) begin
            w_q     <= cfg_width_i;
            h_q     <= cfg_height_i;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= RUN;
          end
        end
        (state_q == RUN): begin
          if (accept) begin
            if (last_col) begin
              col_q <= '0;
              row_q <= row_q + ONE;
            end else begin
              col_q <= col_q + ONE;
            end
            if (last_pix) begin
              state_q <= DRAIN;
            end
          end
        end
        (state_q == DRAIN): begin
          if (win_hs) begin
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    win_data_o                  = '0;
    win_data_o[WIN_C*8  +: 8]   = w_m[1];
    win_data_o[WIN_N*8  +: 8]   = w_t[1];
    win_data_o[WIN_W*8  +: 8]   = w_m[0];
    win_data_o[WIN_E*8  +: 8]   = w_m[2];
    win_data_o[WIN_S*8  +: 8]   = w_b[1];
    win_data_o[WIN_NW*8 +: 8]   = w_t[0];
    win_data_o[WIN_NE*8 +: 8]   = w_t[2];
    win_data_o[WIN_SW*8 +: 8]   = w_b[0];
    win_data_o[WIN_SE*8 +: 8]   = w_b[2];
  end

`ifdef IBEX_VWIN_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || start_ok) begin
      stall_q <= '0;
    end else if (win_valid_q && !win_ready_i &&
                 stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/ibex_vector_window_gen.md
Name: ibex_vector_window_gen

Overview:
Streaming 3x3 pixel-window generator that feeds the vector filter datapath. It accepts a raster-order 8-bit pixel stream and buffers two image lines. For every interior pixel it emits one 128-bit packed window in the byte layout the vector MAC array expects: centre in byte 0, the 4-neighbours in bytes 1-4, the corners in bytes 5-8. It sits between the pixel source (DMA/LSU side) and the vector register operand vector_reg_1.

Parameters:
MAX_WIDTH, 64, maximum supported line width in pixels; sets line-buffer depth; must be >= 3.
DIM_W, 7, width of the cfg_width_i / cfg_height_i fields; must satisfy 2**DIM_W > MAX_WIDTH.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  single-cycle frame start; cfg_* sampled on this cycle
cfg_width_i  in  DIM_W  frame width W in pixels
cfg_height_i  in  DIM_W  frame height H in lines
cfg_err_o  out  1  one-cycle pulse: start_i rejected because of a bad config
busy_o  out  1  high from accepted start until frame done
pix_valid_i  in  1  input pixel valid
pix_ready_o  out  1  input pixel ready
pix_data_i  in  8  unsigned pixel
win_valid_o  out  1  window valid
win_ready_i  in  1  window accepted by consumer
win_data_o  out  128  packed window; bits [127:72] always zero
frame_done_o  out  1  one-cycle pulse after the last window handshake
stall_cnt_o  out  16  backpressure statistic (see Optional Feature)

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, row/col counters 0. Line-buffer contents are not cleared.
- Reset asserted mid-frame aborts the frame immediately. No frame_done_o is produced and no partial window is emitted.
- FSM IDLE:
  - pix_ready_o = 0.
  - On start_i with 3 <= W <= MAX_WIDTH and H >= 3: latch W and H, clear counters, go to RUN, busy_o = 1.
  - Any other config: pulse cfg_err_o next cycle and stay in IDLE.
- start_i is ignored while busy_o = 1.
- FSM RUN:
  - pix_ready_o = !win_valid_o || win_ready_i (single output register, no bubble under continuous ready).
  - A pixel is accepted on pix_valid_i && pix_ready_o, at position (row r, col c).
- On accept, the line buffers are read-before-write at address c:
  - a = lb0[c] (row r-1), b = lb1[c] (row r-2).
  - lb1[c] <= a; lb0[c] <= pix.
  - Column triple {b, a, pix} shifts into a 3-column window register (oldest column dropped).
- Window emission:
  - If r >= 2 and c >= 2, win_valid_o rises the next cycle (latency 1).
  - The window is centred at (r-1, c-1). Rows of the register are top = row r-2, mid = row r-1, bottom = row r.
  - Byte layout: byte0 = C, 1 = N, 2 = W, 3 = E, 4 = S, 5 = NW, 6 = NE, 7 = SW, 8 = SE.
- win_valid_o/win_data_o hold stable until win_ready_i. A new window may load in the same cycle as a handshake.
- Counters:
  - col wraps W-1 -> 0 with row increment.
  - The window register is not cleared at line start; columns 0-1 of each row only prime it.
- After accepting pixel (H-1, W-1), go to DRAIN (pix_ready_o = 0).
- DRAIN: when the pending window handshakes, pulse frame_done_o, drop busy_o, go to IDLE.
- Exactly (W-2)*(H-2) windows per frame. Border pixels produce no windows.

Optional Feature:
Macro IBEX_VWIN_STALL_CNT_EN.
- Defined: stall_cnt_o counts cycles with win_valid_o && !win_ready_i. It is cleared on accepted start_i and on reset, and saturates at 16'hFFFF.
- Undefined: stall_cnt_o is tied to 0 and no counter logic is instantiated.

Decomposition:
- Package ibex_vector_win_pkg holds:
  - Byte-index localparams WIN_C..WIN_SE (0..8).
  - WIN_BYTES = 9.
  - FSM enum {IDLE, RUN, DRAIN}.
- Sub-module ibex_vector_line_buf: a MAX_WIDTH x 8 register array with one combinational read port and one write port at the same address. Two instances are used (lb0, lb1).

Test Plan:
- W=4, H=4, pixels 0..15, ready always 1 -> 4 windows.
  - First window: bytes0..8 = 5,1,4,6,9,0,2,8,10.
  - Last window: centre 10, SE 15.
  - frame_done_o exactly once, 1 cycle after the 4th handshake.
- Same frame with win_ready_i low for 5 cycles on the 2nd window:
  - pix_ready_o low during the stall.
  - win_data_o is stable during the stall.
  - No window is lost or duplicated.
  - With the macro defined, stall_cnt_o = 5.
- start_i with W=2, and separately W=MAX_WIDTH+1 -> cfg_err_o pulses and busy_o stays 0. W=3, H=3 -> exactly one window, centre = pixel 4.
- W=MAX_WIDTH, H=3, ramp pixels (i mod 256) -> MAX_WIDTH-2 windows. Centre of window k = (MAX_WIDTH+1+k) mod 256.
- rst_i asserted after 7 pixels of a 4x4 frame, then a fresh 4x4 frame -> windows are identical to the first scenario and no stale data appears.
